// File: rtl/bch_enc_sched.sv
// Two-requester frame scheduler in front of a BCH encoder: round-robin frame grant,
// frame length policing and a drain window that keeps data clear of encoder parity.
module bch_enc_sched #(
    parameter int C_DWIDTH    = 128,
    parameter int C_ECC_WORDS = 5,
    parameter int C_MAX_WORDS = 64
) (
    input  logic                I_clk,
    input  logic                I_rst,
    input  logic [C_DWIDTH-1:0] I_req0_data,
    input  logic                I_req0_v,
    input  logic                I_req0_sof,
    input  logic                I_req0_eof,
    output logic                O_req0_rdy,
    input  logic [C_DWIDTH-1:0] I_req1_data,
    input  logic                I_req1_v,
    input  logic                I_req1_sof,
    input  logic                I_req1_eof,
    output logic                O_req1_rdy,
    output logic [C_DWIDTH-1:0] O_enc_data,
    output logic                O_enc_v,
    output logic                O_enc_sof,
    output logic                O_enc_eof,
    output logic                O_enc_id,
    output logic [15:0]         O_frame_cnt,
    output logic                O_err_sof,
    output logic                O_err_len
);

    localparam int BEAT_W  = $clog2(C_MAX_WORDS + 1);
    localparam int DRAIN_W = $clog2(C_ECC_WORDS + 2);
    localparam logic [BEAT_W-1:0]  LAST_BEAT  = BEAT_W'(C_MAX_WORDS - 1);
    localparam logic [DRAIN_W-1:0] DRAIN_LOAD = DRAIN_W'(C_ECC_WORDS);
    localparam logic [DRAIN_W-1:0] DRAIN_ONE  = DRAIN_W'(1);

    typedef enum logic [1:0] {
        IDLE,
        XFER,
        FLUSH,
        DRAIN
    } state_t;

    state_t               state;
    logic                 rr;
    logic [BEAT_W-1:0]    beat_cnt;
    logic [DRAIN_W-1:0]   drain_cnt;

    logic                 cand0;
    logic                 cand1;
    logic                 grant_sel;
    logic                 stray;
    logic [C_DWIDTH-1:0]  sel_data;
    logic                 sel_v;
    logic                 sel_eof;
    logic                 last_beat;

    assign cand0     = I_req0_v & I_req0_sof;
    assign cand1     = I_req1_v & I_req1_sof;
    // rr only matters on a tie; a lone candidate always wins
    assign grant_sel = (cand0 & cand1) ? rr : cand1;
    assign stray     = (I_req0_v & ~I_req0_sof) | (I_req1_v & ~I_req1_sof);

    assign sel_data  = O_enc_id ? I_req1_data : I_req0_data;
    assign sel_v     = O_enc_id ? I_req1_v    : I_req0_v;
    assign sel_eof   = O_enc_id ? I_req1_eof  : I_req0_eof;
    assign last_beat = (beat_cnt == LAST_BEAT);

    always_comb begin
        O_req0_rdy = 1'b0;
        O_req1_rdy = 1'b0;
        if (!I_rst) begin
            case (state)
                IDLE: begin
                    O_req0_rdy = I_req0_v & ~I_req0_sof;
                    O_req1_rdy = I_req1_v & ~I_req1_sof;
                end
                XFER, FLUSH: begin
                    O_req0_rdy = ~O_enc_id;
                    O_req1_rdy = O_enc_id;
                end
                default: begin
                    O_req0_rdy = 1'b0;
                    O_req1_rdy = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge I_clk) begin
        if (I_rst) begin
            state       <= IDLE;
            rr          <= 1'b0;
            beat_cnt    <= '0;
            drain_cnt   <= '0;
            O_enc_data  <= '0;
            O_enc_v     <= 1'b0;
            O_enc_sof   <= 1'b0;
            O_enc_eof   <= 1'b0;
            O_enc_id    <= 1'b0;
            O_frame_cnt <= '0;
            O_err_sof   <= 1'b0;
            O_err_len   <= 1'b0;
        end else begin
            O_enc_v   <= 1'b0;
            O_enc_sof <= 1'b0;
            O_enc_eof <= 1'b0;
            case (state)
                IDLE: begin
                    if (stray) begin
                        O_err_sof <= 1'b1;
                    end
                    if (cand0 | cand1) begin
                        O_enc_id <= grant_sel;
                        beat_cnt <= '0;
                        state    <= XFER;
                    end
                end
                XFER: begin
                    if (sel_v) begin
                        O_enc_data <= sel_data;
                        O_enc_v    <= 1'b1;
                        O_enc_sof  <= (beat_cnt == '0);
                        O_enc_eof  <= sel_eof | last_beat;
                        beat_cnt   <= beat_cnt + 1'b1;
                        // a frame hitting the length cap is closed early and its tail flushed
                        if (sel_eof | last_beat) begin
                            O_frame_cnt <= O_frame_cnt + 16'd1;
                            rr          <= ~O_enc_id;
                            if (sel_eof) begin
                                drain_cnt <= DRAIN_LOAD;
                                state     <= DRAIN;
                            end else begin
                                O_err_len <= 1'b1;
                                state     <= FLUSH;
                            end
                        end
                    end
                end
                FLUSH: begin
                    if (sel_v & sel_eof) begin
                        drain_cnt <= DRAIN_LOAD;
                        state     <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (drain_cnt <= DRAIN_ONE) begin
                        drain_cnt <= '0;
                        state     <= IDLE;
                    end else begin
                        drain_cnt <= drain_cnt - 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_bch_enc_sched.sv
// Scoreboard bench for bch_enc_sched: per-channel expected-word queues filled by the
// frame drivers, drained by a monitor that watches the encoder-side stream.
`timescale 1ns/1ps
module tb_bch_enc_sched;

    localparam int W = 128;
    localparam int E = 5;
    localparam int M = 64;

    typedef struct packed {
        logic [W-1:0] data;
        logic         sof;
        logic         eof;
    } word_t;

    logic          I_clk = 1'b0;
    logic          I_rst = 1'b1;
    logic [W-1:0]  d   [2];
    logic          v   [2];
    logic          sof [2];
    logic          eof [2];
    logic          O_req0_rdy, O_req1_rdy;
    logic [W-1:0]  O_enc_data;
    logic          O_enc_v, O_enc_sof, O_enc_eof, O_enc_id;
    logic [15:0]   O_frame_cnt;
    logic          O_err_sof, O_err_len;

    word_t  q0[$];
    word_t  q1[$];
    int     id_log[$];
    int     sof_log[$];
    int     checks = 0;
    int     errors = 0;
    int     cyc = 0;
    int     exp_frames = 0;
    int     gap = 0;
    bit     gap_valid = 0;
    bit     exp_err_len = 0;
    logic [W-1:0] last_data = '0;

    bch_enc_sched #(
        .C_DWIDTH(W),
        .C_ECC_WORDS(E),
        .C_MAX_WORDS(M)
    ) dut (
        .I_clk(I_clk),
        .I_rst(I_rst),
        .I_req0_data(d[0]),
        .I_req0_v(v[0]),
        .I_req0_sof(sof[0]),
        .I_req0_eof(eof[0]),
        .O_req0_rdy(O_req0_rdy),
        .I_req1_data(d[1]),
        .I_req1_v(v[1]),
        .I_req1_sof(sof[1]),
        .I_req1_eof(eof[1]),
        .O_req1_rdy(O_req1_rdy),
        .O_enc_data(O_enc_data),
        .O_enc_v(O_enc_v),
        .O_enc_sof(O_enc_sof),
        .O_enc_eof(O_enc_eof),
        .O_enc_id(O_enc_id),
        .O_frame_cnt(O_frame_cnt),
        .O_err_sof(O_err_sof),
        .O_err_len(O_err_len)
    );

    always #5 I_clk = ~I_clk;

    always @(posedge I_clk) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic logic rdyOf(input int ch);
        return (ch == 0) ? O_req0_rdy : O_req1_rdy;
    endfunction

    // Monitor: every presented encoder word must be the next expected word of its owner
    always @(negedge I_clk) begin
        word_t e;
        if (O_enc_v === 1'b1) begin
            if (O_enc_sof) begin
                if (gap_valid) checkOutput("gap_after_eof", W'(gap >= E + 1), W'(1));
                id_log.push_back(int'(O_enc_id));
                sof_log.push_back(cyc);
            end
            if ((O_enc_id ? q1.size() : q0.size()) == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL unexpected_word: got data %0h on id %0d, expected no word", O_enc_data, O_enc_id);
            end else begin
                if (O_enc_id) e = q1.pop_front();
                else          e = q0.pop_front();
                checkOutput("enc_data", O_enc_data, e.data);
                checkOutput("enc_sof", W'(O_enc_sof), W'(e.sof));
                checkOutput("enc_eof", W'(O_enc_eof), W'(e.eof));
                if (e.eof) begin
                    exp_frames++;
                    checkOutput("frame_cnt", W'(O_frame_cnt), W'(16'(exp_frames)));
                end
            end
            last_data = O_enc_data;
            if (O_enc_eof) begin
                gap = 0;
                gap_valid = 1;
            end
        end else begin
            gap++;
            checkOutput("idle_sof_eof", W'({O_enc_sof, O_enc_eof}), W'(0));
            checkOutput("idle_data_hold", O_enc_data, last_data);
        end
        if (I_rst) begin
            gap_valid = 0;
            gap = 0;
            exp_frames = 0;
            last_data = '0;
        end
    end

    task automatic waitAccept(input int ch);
        int n = 0;
        @(negedge I_clk);
        while (rdyOf(ch) !== 1'b1 && n < 4000) begin
            n++;
            @(negedge I_clk);
        end
        if (n >= 4000) begin
            checks++;
            errors++;
            $display("[TB] FAIL handshake_timeout: ch%0d rdy stayed 0, expected 1", ch);
        end
        @(posedge I_clk);
        #1;
    endtask

    // Drives one frame on a channel; the expected encoder words follow from the length cap
    task automatic applyStimulus(input int ch, input int len, input int gap_pct);
        word_t w;
        logic [W-1:0] data;
        if (len > M) exp_err_len = 1;
        for (int i = 0; i < len; i++) begin
            data = {$urandom, $urandom, $urandom, $urandom};
            if (i < M) begin
                w.data = data;
                w.sof  = (i == 0);
                w.eof  = (i == len - 1) || (i == M - 1);
                if (ch == 0) q0.push_back(w);
                else         q1.push_back(w);
            end
            while (gap_pct > 0 && int'($urandom_range(99)) < gap_pct) begin
                v[ch] = 1'b0;
                @(posedge I_clk);
                #1;
            end
            d[ch]   = data;
            v[ch]   = 1'b1;
            sof[ch] = (i == 0);
            eof[ch] = (i == len - 1);
            waitAccept(ch);
        end
        v[ch]   = 1'b0;
        sof[ch] = 1'b0;
        eof[ch] = 1'b0;
    endtask

    task automatic resetDut();
        I_rst  = 1'b1;
        v[0]   = 1'b1;
        sof[0] = 1'b0;
        v[1]   = 1'b1;
        sof[1] = 1'b1;
        @(posedge I_clk);
        #1;
        q0.delete();
        q1.delete();
        exp_err_len = 0;
        @(negedge I_clk);
        checkOutput("rst_rdy0", W'(O_req0_rdy), W'(0));
        checkOutput("rst_rdy1", W'(O_req1_rdy), W'(0));
        checkOutput("rst_enc_v", W'(O_enc_v), W'(0));
        checkOutput("rst_enc_sof_eof", W'({O_enc_sof, O_enc_eof}), W'(0));
        checkOutput("rst_enc_data", O_enc_data, W'(0));
        checkOutput("rst_enc_id", W'(O_enc_id), W'(0));
        checkOutput("rst_frame_cnt", W'(O_frame_cnt), W'(0));
        checkOutput("rst_err_flags", W'({O_err_sof, O_err_len}), W'(0));
        @(posedge I_clk);
        #1;
        I_rst = 1'b0;
        for (int c = 0; c < 2; c++) begin
            v[c]   = 1'b0;
            sof[c] = 1'b0;
            eof[c] = 1'b0;
            d[c]   = '0;
        end
    endtask

    task automatic waitDrain();
        int n = 0;
        while ((q0.size() != 0 || q1.size() != 0) && n < 20000) begin
            @(negedge I_clk);
            n++;
        end
        if (n >= 20000) begin
            checks++;
            errors++;
            $display("[TB] FAIL drain_timeout: %0d words still expected, expected 0", q0.size() + q1.size());
        end
        repeat (E + 3) @(posedge I_clk);
        #1;
    endtask

    initial begin
        #5000000;
        $display("[TB] FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int start;
        word_t w;
        for (int c = 0; c < 2; c++) begin
            v[c] = 1'b0; sof[c] = 1'b0; eof[c] = 1'b0; d[c] = '0;
        end
        resetDut();

        // single frame latency and throughput
        id_log.delete(); sof_log.delete();
        start = cyc;
        applyStimulus(0, 3, 0);
        waitDrain();
        checkOutput("single_sof_cycle", W'(sof_log.size() > 0 ? sof_log[0] - start : -1), W'(2));
        checkOutput("single_frame_cnt", W'(O_frame_cnt), W'(1));

        // contention: both channels hold sof from cycle 0
        resetDut();
        id_log.delete(); sof_log.delete();
        start = cyc;
        fork
            begin applyStimulus(0, 3, 0); applyStimulus(0, 3, 0); end
            applyStimulus(1, 3, 0);
        join
        waitDrain();
        checkOutput("contention_frames", W'(id_log.size()), W'(3));
        if (id_log.size() == 3) begin
            checkOutput("contention_id0", W'(id_log[0]), W'(0));
            checkOutput("contention_id1", W'(id_log[1]), W'(1));
            checkOutput("contention_id2", W'(id_log[2]), W'(0));
            checkOutput("contention_sof2_cycle", W'(sof_log[1] - start), W'(4 + E + 2));
            checkOutput("contention_sof3_cycle", W'(sof_log[2] - start), W'(4 + E + 2 + 2 + E + 2));
        end

        // overlength frame on requester 1
        resetDut();
        applyStimulus(1, 70, 0);
        waitDrain();
        checkOutput("overlen_err_len", W'(O_err_len), W'(1));
        checkOutput("overlen_frame_cnt", W'(O_frame_cnt), W'(1));
        checkOutput("overlen_err_sof", W'(O_err_sof), W'(0));

        // stray word while idle
        resetDut();
        d[0] = {$urandom, $urandom, $urandom, $urandom};
        v[0] = 1'b1;
        sof[0] = 1'b0;
        @(negedge I_clk);
        checkOutput("stray_rdy0", W'(O_req0_rdy), W'(1));
        @(posedge I_clk);
        #1;
        v[0] = 1'b0;
        repeat (3) @(posedge I_clk);
        #1;
        checkOutput("stray_err_sof", W'(O_err_sof), W'(1));
        applyStimulus(1, 4, 20);
        waitDrain();
        checkOutput("stray_err_sof_sticky", W'(O_err_sof), W'(1));

        // reset in the middle of a 5-word frame
        resetDut();
        w.data = {$urandom, $urandom, $urandom, $urandom}; w.sof = 1'b1; w.eof = 1'b0;
        q0.push_back(w);
        d[0] = w.data; v[0] = 1'b1; sof[0] = 1'b1; eof[0] = 1'b0;
        waitAccept(0);
        w.data = {$urandom, $urandom, $urandom, $urandom}; w.sof = 1'b0;
        q0.push_back(w);
        d[0] = w.data; sof[0] = 1'b0;
        waitAccept(0);
        d[0] = {$urandom, $urandom, $urandom, $urandom};
        resetDut();
        applyStimulus(0, 3, 0);
        waitDrain();
        checkOutput("post_rst_frame_cnt", W'(O_frame_cnt), W'(1));

        // randomized two-channel run, 1000 frames total
        resetDut();
        fork
            for (int f = 0; f < 500; f++) begin
                applyStimulus(0, ($urandom_range(9) == 0) ? int'($urandom_range(70, 60)) : int'($urandom_range(8, 1)),
                              int'($urandom_range(40)));
                repeat ($urandom_range(3)) @(posedge I_clk);
                #1;
            end
            for (int f = 0; f < 500; f++) begin
                applyStimulus(1, ($urandom_range(9) == 0) ? int'($urandom_range(70, 60)) : int'($urandom_range(8, 1)),
                              int'($urandom_range(40)));
                repeat ($urandom_range(3)) @(posedge I_clk);
                #1;
            end
        join
        waitDrain();
        checkOutput("random_frame_cnt", W'(O_frame_cnt), W'(1000));
        checkOutput("random_err_len", W'(O_err_len), W'(exp_err_len));
        checkOutput("random_err_sof", W'(O_err_sof), W'(0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
